// File: rtl/xa_flow_monitor.sv
// Discharge-sensor flow monitor.
// Synchronises the sensor pulse line and measures rise-to-rise periods.
// Reports flow confirmed, no flow, or a latched dry-run alarm to the pump controller.
module xa_flow_monitor #(
  parameter int unsigned PER_MIN = 40000,
  parameter int unsigned PER_MAX = 60000,
  parameter int unsigned TIMEOUT = 150000,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned CNT_W   = 18,
  parameter int unsigned EC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             alarm_clr,
  input  logic             xa_in,
  output logic             flow_ok,
  output logic             no_flow,
  output logic             dry_alarm,
  output logic             period_err,
  output logic [CNT_W-1:0] last_period,
  output logic [EC_W-1:0]  edge_cnt,
  output logic [2:0]       state
);

  // One extra bit so that a period of TIMEOUT+1 never wraps.
  localparam int unsigned PW = CNT_W + 1;
  localparam int unsigned GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [PW-1:0]    PerOne   = PW'(1);
  localparam logic [PW-1:0]    PerMinC  = PW'(PER_MIN);
  localparam logic [PW-1:0]    PerMaxC  = PW'(PER_MAX);
  localparam logic [GW-1:0]    GoodOne  = GW'(1);
  localparam logic [GW-1:0]    GoodLast = GW'(LOCK_N - 1);
  localparam logic [EC_W-1:0]  EcOne    = EC_W'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StAcq   = 3'd2,
    StFlow  = 3'd3,
    StAlarm = 3'd4
  } state_e;

  state_e           st_q;
  logic             s1, s2, s3;
  logic             rise;
  logic             timeout;
  logic             in_range;
  logic [CNT_W-1:0] per_cnt;
  logic [PW-1:0]    period;
  logic [GW-1:0]    good_cnt;

  assign rise     = s2 & ~s3;
  assign period   = {1'b0, per_cnt} + PerOne;
  assign in_range = (period >= PerMinC) && (period <= PerMaxC);
  // A rise in the same cycle as saturation wins over the timeout.
  assign timeout  = (per_cnt == TimeoutC) && !rise;
  assign state    = st_q;

  // Three-flop synchroniser for the asynchronous sensor line.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= xa_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Flow FSM with period counter, lock counter and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      per_cnt     <= '0;
      good_cnt    <= '0;
      last_period <= '0;
      edge_cnt    <= '0;
      flow_ok     <= 1'b0;
      no_flow     <= 1'b0;
      dry_alarm   <= 1'b0;
      period_err  <= 1'b0;
    end else begin
      period_err <= 1'b0;
      if (en && rise) begin
        edge_cnt <= edge_cnt + EcOne;
      end
      if (!en) begin
        st_q      <= StIdle;
        per_cnt   <= '0;
        good_cnt  <= '0;
        flow_ok   <= 1'b0;
        no_flow   <= 1'b0;
        dry_alarm <= 1'b0;
      end else begin
        if (rise) begin
          per_cnt <= '0;
        end else if (per_cnt != TimeoutC) begin
          per_cnt <= per_cnt + CntOne;
        end
        unique case (st_q)
          StIdle: begin
            per_cnt <= '0;
            no_flow <= 1'b1;
            st_q    <= StWait;
          end
          StWait: begin
            if (rise) begin
              good_cnt <= '0;
              st_q     <= StAcq;
            end
          end
          StAcq: begin
            if (rise) begin
              last_period <= period[CNT_W-1:0];
              if (in_range) begin
                if (good_cnt == GoodLast) begin
                  good_cnt <= '0;
                  no_flow  <= 1'b0;
                  flow_ok  <= 1'b1;
                  st_q     <= StFlow;
                end else begin
                  good_cnt <= good_cnt + GoodOne;
                end
              end else begin
                period_err <= 1'b1;
                good_cnt   <= '0;
              end
            end else if (timeout) begin
              st_q <= StWait;
            end
          end
          StFlow: begin
            if (rise) begin
              last_period <= period[CNT_W-1:0];
              if (!in_range) begin
                period_err <= 1'b1;
                good_cnt   <= '0;
                flow_ok    <= 1'b0;
                no_flow    <= 1'b1;
                st_q       <= StAcq;
              end
            end else if (timeout) begin
              flow_ok   <= 1'b0;
              dry_alarm <= 1'b1;
              st_q      <= StAlarm;
            end
          end
          StAlarm: begin
            if (alarm_clr) begin
              per_cnt   <= '0;
              dry_alarm <= 1'b0;
              no_flow   <= 1'b1;
              st_q      <= StWait;
            end
          end
          default: begin
            flow_ok   <= 1'b0;
            no_flow   <= 1'b0;
            dry_alarm <= 1'b0;
            st_q      <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xa_flow_monitor.sv
// Scoreboard bench for xa_flow_monitor: directed scenarios followed by random pulse trains.
module tb_xa_flow_monitor;

  localparam int unsigned PMIN = 8;
  localparam int unsigned PMAX = 12;
  localparam int unsigned TO   = 30;
  localparam int unsigned LOCK = 4;
  localparam int unsigned CW   = 5;
  localparam int unsigned EW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          alarm_clr = 1'b0;
  logic          xa_in = 1'b0;
  logic          flow_ok, no_flow, dry_alarm, period_err;
  logic [CW-1:0] last_period;
  logic [EW-1:0] edge_cnt;
  logic [2:0]    state;

  xa_flow_monitor #(
    .PER_MIN(PMIN), .PER_MAX(PMAX), .TIMEOUT(TO), .LOCK_N(LOCK), .CNT_W(CW), .EC_W(EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .alarm_clr  (alarm_clr),
    .xa_in      (xa_in),
    .flow_ok    (flow_ok),
    .no_flow    (no_flow),
    .dry_alarm  (dry_alarm),
    .period_err (period_err),
    .last_period(last_period),
    .edge_cnt   (edge_cnt),
    .state      (state)
  );

  initial forever #5 clk = ~clk;

  logic [15:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: xa history, cycles since last rise, mode 0..4 as the reported code.
  bit m_x1, m_x2, m_x3, m_perr;
  int m_since, m_mode, m_good, m_lp, m_edges;

  function automatic void model_step(input bit r, input bit e, input bit c, input bit x);
    bit rise, to;
    int per, nsince;
    if (r) begin
      m_x1 = 0; m_x2 = 0; m_x3 = 0; m_perr = 0;
      m_since = 0; m_mode = 0; m_good = 0; m_lp = 0; m_edges = 0;
      return;
    end
    rise = m_x2 && !m_x3;
    m_x3 = m_x2; m_x2 = m_x1; m_x1 = x;
    to = (m_since == TO) && !rise;
    per = m_since + 1;
    m_perr = 0;
    if (e && rise) m_edges = (m_edges + 1) % (1 << EW);
    if (!e) begin
      m_mode = 0; m_since = 0; m_good = 0;
      return;
    end
    nsince = rise ? 0 : ((m_since + 1 > TO) ? TO : m_since + 1);
    case (m_mode)
      0: begin m_mode = 1; nsince = 0; end
      1: if (rise) begin m_mode = 2; m_good = 0; end
      2: if (rise) begin
           m_lp = per;
           if (per >= PMIN && per <= PMAX) begin
             m_good++;
             if (m_good == LOCK) begin m_mode = 3; m_good = 0; end
           end else begin
             m_perr = 1; m_good = 0;
           end
         end else if (to) m_mode = 1;
      3: if (rise) begin
           m_lp = per;
           if (per < PMIN || per > PMAX) begin m_perr = 1; m_mode = 2; m_good = 0; end
         end else if (to) m_mode = 4;
      default: if (c) begin m_mode = 1; nsince = 0; end
    endcase
    m_since = nsince;
  endfunction

  function automatic logic [15:0] model_out();
    logic fo, nf, da;
    logic [CW-1:0] lp;
    logic [EW-1:0] ec;
    logic [2:0] st;
    fo = (m_mode == 3);
    nf = (m_mode == 1 || m_mode == 2);
    da = (m_mode == 4);
    lp = CW'(m_lp);
    ec = EW'(m_edges);
    st = 3'(m_mode);
    return {fo, nf, da, m_perr, lp, ec, st};
  endfunction

  task automatic step(input bit r, input bit e, input bit c, input bit x);
    @(negedge clk);
    rst = r; en = e; alarm_clr = c; xa_in = x;
    model_step(r, e, c, x);
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input int n, input bit x);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, x);
  endtask

  task automatic wave(input int p, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) step(1'b0, 1'b1, 1'b0, i < p / 2);
  endtask

  // Monitor: compares every registered output just after each active edge.
  initial begin
    logic [15:0] exp, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {flow_ok, no_flow, dry_alarm, period_err, last_period, edge_cnt, state};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got fo/nf/da/pe=%b lp=%0d ec=%0d st=%0d, want fo/nf/da/pe=%b lp=%0d ec=%0d st=%0d",
                   cyc, got[15:12], got[11:7], got[6:3], got[2:0],
                   exp[15:12], exp[11:7], exp[6:3], exp[2:0]);
        end
      end
    end
  end

  initial begin
    int p, hi;
    bit ren;
    // Reset, then enable with the line idle.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    hold(6, 1'b0);
    // Lock onto a 10-cycle square wave.
    wave(10, 7);
    // One long period knocks back to ACQ, then re-lock.
    wave(20, 1);
    wave(10, 5);
    // Line stuck low raises the alarm; pulses do not clear it; alarm_clr does.
    hold(40, 1'b0);
    wave(10, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    // Rise coinciding with saturation stays in ACQ; then short periods.
    hold(5, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    hold(30, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    hold(3, 1'b0);
    wave(5, 3);
    // Lock, drop enable in FLOW, re-enable, then reset in ACQ.
    wave(10, 6);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, i < 2);
    hold(3, 1'b0);
    wave(10, 2);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    // Random pulse trains with occasional enable drops, clears, gaps and resets.
    ren = 1'b1;
    repeat (300) begin
      if ($urandom_range(3, 0) != 0) p = $urandom_range(PMAX, PMIN);
      else p = $urandom_range(40, 3);
      hi = $urandom_range(p - 1, 1);
      if ($urandom_range(15, 0) == 0) hold($urandom_range(45, 25), $urandom_range(1, 0) == 1);
      for (int i = 0; i < p; i++) begin
        if ($urandom_range(199, 0) == 0) ren = !ren;
        step($urandom_range(999, 0) == 0, ren, $urandom_range(24, 0) == 0, i < hi);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
